// File: rtl/mainmenu_select_ctrl.sv
// mainmenu_select_ctrl: debounced five-button cursor over the main-menu options with a one-cycle start strobe
module mainmenu_select_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W = 19
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_select,
  input  logic        menu_active,
  output logic [2:0]  menu_sel,
  output logic [28:0] metadata,
  output logic        start_pulse,
  output logic [2:0]  start_mode
);
  typedef enum logic [1:0] {S_OFF, S_BROWSE, S_START, S_LAUNCHED} state_t;
  state_t state_q;
  logic [4:0] raw, sync1_q, sync2_q, lvl_q, prev_q, rise;
  logic [CNT_W-1:0] cnt_q [5];
  logic [2:0] sel_q, sel_d, mode_q, up_s, down_s, left_s, right_s;
  logic pulse_q;
  // bit order: 0=up 1=down 2=left 3=right 4=select
  assign raw = {btn_select, btn_right, btn_left, btn_down, btn_up};
  assign rise = lvl_q & ~prev_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      lvl_q <= '0;
      prev_q <= '0;
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      prev_q <= lvl_q;
      for (int i = 0; i < 5; i++) begin
        if (sync2_q[i] == lvl_q[i]) cnt_q[i] <= '0;
        else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          lvl_q[i] <= ~lvl_q[i];
          cnt_q[i] <= '0;
        end else cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end
  // left column is 0..2, right column is 3..4; moves saturate at the edges
  always_comb begin
    up_s = (sel_q == 3'd0 || sel_q == 3'd3) ? sel_q : sel_q - 3'd1;
    down_s = (sel_q == 3'd0 || sel_q == 3'd1 || sel_q == 3'd3) ? sel_q + 3'd1 : sel_q;
    left_s = (sel_q >= 3'd3) ? sel_q - 3'd3 : sel_q;
    right_s = (sel_q == 3'd0) ? 3'd3 : (sel_q == 3'd1 || sel_q == 3'd2) ? 3'd4 : sel_q;
    sel_d = rise[0] ? up_s : rise[1] ? down_s : rise[2] ? left_s : rise[3] ? right_s : sel_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_OFF;
      sel_q <= '0;
      mode_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        S_OFF: begin
          sel_q <= '0;
          if (menu_active) state_q <= S_BROWSE;
        end
        S_BROWSE: begin
          if (!menu_active) begin
            state_q <= S_OFF;
            sel_q <= '0;
          end else if (rise[4]) begin
            mode_q <= sel_q;
            pulse_q <= 1'b1;
            state_q <= S_START;
          end else sel_q <= sel_d;
        end
        S_START: state_q <= S_LAUNCHED;
        S_LAUNCHED: begin
          if (!menu_active) begin
            state_q <= S_OFF;
            sel_q <= '0;
          end
        end
        default: state_q <= S_OFF;
      endcase
    end
  end
  assign menu_sel = sel_q;
  assign metadata = {sel_q, 26'd0};
  assign start_pulse = pulse_q;
  assign start_mode = mode_q;
endmodule
